wca_agc_ctrl: RTL and testbench

//  Automatic gain controller fed by the 8-bit RSSI estimator output. It waits for the

---
 rtl/wca_agc_if.sv | 24 ++
 rtl/wca_agc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_wca_agc_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wca_agc_if.sv
// Control/status bundle between the AGC loop, the RSSI stage and the gain register bank.
interface wca_agc_if #(
  parameter int unsigned GAIN_W = 6
);
  logic              enable;
  logic              strobe;
  logic [7:0]        rssi;
  logic [7:0]        target;
  logic [7:0]        hyst;
  logic [GAIN_W-1:0] gain;
  logic              gain_update;
  logic              locked;
  logic [7:0]        rssi_avg;

  modport master (
    output enable, strobe, rssi, target, hyst,
    input  gain, gain_update, locked, rssi_avg
  );

  modport slave (
    input  enable, strobe, rssi, target, hyst,
    output gain, gain_update, locked, rssi_avg
  );
endinterface

// File: rtl/wca_agc_ctrl.sv
// Automatic gain loop: settle, average 2^AVG_LOG2 strobed RSSI samples, then nudge the
// gain code by one step to keep the average inside target +/- hyst.
module wca_agc_ctrl #(
  parameter int unsigned GAIN_W     = 6,
  parameter int unsigned GAIN_MIN   = 0,
  parameter int unsigned GAIN_MAX   = 63,
  parameter int unsigned GAIN_INIT  = 32,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned AVG_LOG2   = 3
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  wca_agc_if.slave   agc_io
);

  localparam int unsigned ACC_W     = 8 + AVG_LOG2;
  localparam int unsigned AVG_CNT_W = AVG_LOG2 + 1;
  localparam int unsigned SET_W     = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam bit          NO_SETTLE = (SETTLE_CYC == 0);

  localparam logic [AVG_CNT_W-1:0] AVG_LAST    = AVG_CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [GAIN_W-1:0]    G_MIN       = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0]    G_MAX       = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0]    G_INIT      = GAIN_W'(GAIN_INIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_DECIDE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [AVG_CNT_W-1:0] avg_cnt_q, avg_cnt_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [GAIN_W-1:0]    gain_q, gain_d;
  logic                 gain_update_q, gain_update_d;
  logic                 locked_q, locked_d;
  logic [7:0]           rssi_avg_q, rssi_avg_d;

  logic [ACC_W-1:0] acc_sum;
  logic [8:0]       lo_diff, hi_sum;
  logic [7:0]       win_lo, win_hi;
  logic             above_win, below_win, go_down, go_up;
  logic             settle_done, avg_done;

  // Dead-band edges computed in 9 bits and saturated to the 8-bit RSSI range
  always_comb begin
    lo_diff   = {1'b0, agc_io.target} - {1'b0, agc_io.hyst};
    hi_sum    = {1'b0, agc_io.target} + {1'b0, agc_io.hyst};
    win_lo    = lo_diff[8] ? 8'd0 : lo_diff[7:0];
    win_hi    = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    above_win = (rssi_avg_q > win_hi);
    below_win = (rssi_avg_q < win_lo);
    go_down   = above_win && (gain_q > G_MIN);
    go_up     = below_win && (gain_q < G_MAX);
  end

  assign acc_sum     = acc_q + ACC_W'(agc_io.rssi);
  assign settle_done = (state_q == S_SETTLE) && agc_io.strobe && (settle_cnt_q == SET_W'(1));
  assign avg_done    = (state_q == S_ACCUM) && agc_io.strobe && (avg_cnt_q == AVG_LAST);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!agc_io.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = NO_SETTLE ? S_ACCUM : S_SETTLE;
        S_SETTLE: if (settle_done) state_d = S_ACCUM;
        S_ACCUM:  if (avg_done) state_d = S_DECIDE;
        S_DECIDE: state_d = ((go_down || go_up) && !NO_SETTLE) ? S_SETTLE : S_ACCUM;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; gain only moves in DECIDE
  always_comb begin
    acc_d         = acc_q;
    avg_cnt_d     = avg_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    locked_d      = locked_q;
    rssi_avg_d    = rssi_avg_q;
    if (!agc_io.enable) begin
      locked_d     = 1'b0;
      acc_d        = '0;
      avg_cnt_d    = '0;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          settle_cnt_d = SETTLE_LOAD;
          acc_d        = '0;
          avg_cnt_d    = '0;
        end
        S_SETTLE: begin
          if (agc_io.strobe) settle_cnt_d = settle_cnt_q - SET_W'(1);
          if (settle_done) begin
            acc_d     = '0;
            avg_cnt_d = '0;
          end
        end
        S_ACCUM: begin
          if (agc_io.strobe) begin
            if (avg_done) begin
              rssi_avg_d = 8'(acc_sum >> AVG_LOG2);
              acc_d      = '0;
              avg_cnt_d  = '0;
            end else begin
              acc_d     = acc_sum;
              avg_cnt_d = avg_cnt_q + AVG_CNT_W'(1);
            end
          end
        end
        S_DECIDE: begin
          acc_d     = '0;
          avg_cnt_d = '0;
          if (go_down) begin
            gain_d        = gain_q - GAIN_W'(1);
            gain_update_d = 1'b1;
            locked_d      = 1'b0;
            settle_cnt_d  = SETTLE_LOAD;
          end else if (go_up) begin
            gain_d        = gain_q + GAIN_W'(1);
            gain_update_d = 1'b1;
            locked_d      = 1'b0;
            settle_cnt_d  = SETTLE_LOAD;
          end else begin
            locked_d = !above_win && !below_win;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q         <= '0;
      avg_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      gain_q        <= G_INIT;
      gain_update_q <= 1'b0;
      locked_q      <= 1'b0;
      rssi_avg_q    <= 8'd0;
    end else begin
      acc_q         <= acc_d;
      avg_cnt_q     <= avg_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      locked_q      <= locked_d;
      rssi_avg_q    <= rssi_avg_d;
    end
  end

  assign agc_io.gain        = gain_q;
  assign agc_io.gain_update = gain_update_q;
  assign agc_io.locked      = locked_q;
  assign agc_io.rssi_avg    = rssi_avg_q;

endmodule

// File: tb/tb_wca_agc_ctrl.sv
// Directed bench for wca_agc_ctrl with default parameters (settle 16, average 8).
module tb_wca_agc_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  wca_agc_if #(.GAIN_W(6)) agc_if ();

  wca_agc_ctrl dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .agc_io   (agc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe every 4 clocks
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      agc_if.strobe = 1'b1;
      step();
      agc_if.strobe = 1'b0;
      step();
      step();
      step();
    end
  endtask

  // n strobes ending in a decision; checks average/gain latency and the update pulse
  task automatic decision(input int n, input logic [7:0] prev_avg, input logic [7:0] exp_avg,
                          input logic [5:0] g_before, input logic [5:0] g_after,
                          input logic exp_lock, input string tag);
    strobes(n - 1);
    chk({tag, ".avg_pre"}, 32'(agc_if.rssi_avg), 32'(prev_avg));
    agc_if.strobe = 1'b1;
    step();
    agc_if.strobe = 1'b0;
    chk({tag, ".avg"}, 32'(agc_if.rssi_avg), 32'(exp_avg));
    chk({tag, ".gain_e1"}, 32'(agc_if.gain), 32'(g_before));
    chk({tag, ".upd_e1"}, 32'(agc_if.gain_update), 32'd0);
    step();
    chk({tag, ".gain_e2"}, 32'(agc_if.gain), 32'(g_after));
    chk({tag, ".upd_e2"}, 32'(agc_if.gain_update), 32'(g_after != g_before));
    chk({tag, ".locked"}, 32'(agc_if.locked), 32'(exp_lock));
    step();
    chk({tag, ".upd_e3"}, 32'(agc_if.gain_update), 32'd0);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n         = 1'b0;
    agc_if.enable = 1'b0;
    agc_if.strobe = 1'b0;
    agc_if.rssi   = 8'd0;
    agc_if.target = 8'd128;
    agc_if.hyst   = 8'd8;
    step();
    step();
    chk("rst.gain", 32'(agc_if.gain), 32'd32);
    chk("rst.locked", 32'(agc_if.locked), 32'd0);
    chk("rst.avg", 32'(agc_if.rssi_avg), 32'd0);
    chk("rst.upd", 32'(agc_if.gain_update), 32'd0);
    rst_n = 1'b1;
    step();

    // Strong signal: gain steps down once per settle+average
    agc_if.enable = 1'b1;
    agc_if.rssi   = 8'd200;
    step();
    decision(24, 8'd0, 8'd200, 6'd32, 6'd31, 1'b0, "down1");
    decision(24, 8'd200, 8'd200, 6'd31, 6'd30, 1'b0, "down2");

    // Async reset in the middle of an average
    strobes(19);
    rst_n = 1'b0;
    #1;
    chk("arst.gain", 32'(agc_if.gain), 32'd32);
    chk("arst.locked", 32'(agc_if.locked), 32'd0);
    chk("arst.avg", 32'(agc_if.rssi_avg), 32'd0);
    chk("arst.upd", 32'(agc_if.gain_update), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // In-window: lock without gain change, then decisions every 8 strobes
    agc_if.rssi = 8'd128;
    decision(24, 8'd0, 8'd128, 6'd32, 6'd32, 1'b1, "lock1");
    agc_if.rssi = 8'd130;
    decision(8, 8'd128, 8'd130, 6'd32, 6'd32, 1'b1, "lock2");

    // Weak signal: climb to the upper clamp
    agc_if.rssi = 8'd10;
    decision(8, 8'd130, 8'd10, 6'd32, 6'd33, 1'b0, "up0");
    for (int i = 1; i < 31; i++) begin
      decision(24, 8'd10, 8'd10, 6'(32 + i), 6'(33 + i), 1'b0, "up");
    end
    chk("clamp.gain", 32'(agc_if.gain), 32'd63);
    decision(24, 8'd10, 8'd10, 6'd63, 6'd63, 1'b0, "clamp1");
    agc_if.rssi = 8'd20;
    decision(8, 8'd10, 8'd20, 6'd63, 6'd63, 1'b0, "clamp2");

    // Window edges saturate at 255 and 0
    agc_if.target = 8'd250;
    agc_if.hyst   = 8'd20;
    agc_if.rssi   = 8'd255;
    decision(8, 8'd20, 8'd255, 6'd63, 6'd63, 1'b1, "hisat");
    agc_if.target = 8'd5;
    agc_if.hyst   = 8'd20;
    agc_if.rssi   = 8'd0;
    decision(8, 8'd255, 8'd0, 6'd63, 6'd63, 1'b1, "losat");

    // Enable dropped mid-average, then full settle on re-enable
    agc_if.rssi = 8'd255;
    strobes(3);
    agc_if.enable = 1'b0;
    step();
    chk("dis.locked", 32'(agc_if.locked), 32'd0);
    chk("dis.gain", 32'(agc_if.gain), 32'd63);
    step();
    agc_if.enable = 1'b1;
    agc_if.rssi   = 8'd200;
    agc_if.target = 8'd128;
    agc_if.hyst   = 8'd8;
    step();
    decision(24, 8'd0, 8'd200, 6'd63, 6'd62, 1'b0, "reen");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
